// File: rtl/pru_fb_pkg.sv
// Shared frame-buffer constants, clear-FSM state type and pixel address map.
package pru_fb_pkg;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 2;
  localparam logic [DATA_W-1:0] CLR_VAL = 2'd0;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  // y*640 + x as (y<<9) + (y<<7) + x; line width is baked into the shifts.
  function automatic logic [ADDR_W-1:0] xy2addr(input logic [9:0] x, input logic [8:0] y);
    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] xw;
    yw = {{(ADDR_W-9){1'b0}}, y};
    xw = {{(ADDR_W-10){1'b0}}, x};
    return (yw << 9) + (yw << 7) + xw;
  endfunction
endpackage

// File: rtl/pru_fb_scan.sv
// Raster scan-out counter and one-cycle pixel-valid pipe for the display read port.
module pru_fb_scan
  import pru_fb_pkg::*;
#(
  parameter int NPIX = H_RES * V_RES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sof_i,
  input  logic              disp_req_i,
  output logic [ADDR_W-1:0] scan_addr_o,
  output logic              pix_valid_o
);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              vld_q;

  // sof wins over a same-cycle request so each frame starts at pixel 0.
  always_comb begin
    cnt_d = cnt_q;
    if (sof_i)
      cnt_d = '0;
    else if (disp_req_i)
      cnt_d = (cnt_q == ADDR_W'(NPIX - 1)) ? '0 : cnt_q + ADDR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= disp_req_i;
    end
  end

  assign scan_addr_o = cnt_q;
  assign pix_valid_o = vld_q;
endmodule

// File: rtl/pru_fb_arbiter.sv
// Frame-buffer controller: raster read sequencing, A>B write arbitration and full-buffer clear.
module pru_fb_arbiter
  import pru_fb_pkg::*;
#(
  parameter int FB_V_RES = V_RES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sof_i,
  input  logic              disp_req_i,
  output logic              pix_valid_o,
  output logic [DATA_W-1:0] pix_data_o,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [9:0]        a_x_i,
  input  logic [8:0]        a_y_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [9:0]        b_x_i,
  input  logic [8:0]        b_y_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              oob_err_o,
  output logic              fb_we_o,
  output logic [ADDR_W-1:0] fb_wr_addr_o,
  output logic [DATA_W-1:0] fb_wr_data_o,
  output logic [ADDR_W-1:0] fb_re_addr_o,
  input  logic [DATA_W-1:0] fb_rd_data_i
);
  localparam int NPIX = H_RES * FB_V_RES;

  clr_state_t        st_q, st_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              we_q, we_d;
  logic              oob_q, oob_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [9:0]        wx;
  logic [8:0]        wy;
  logic [DATA_W-1:0] wdat;

  pru_fb_scan #(.NPIX(NPIX)) u_scan (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sof_i       (sof_i),
    .disp_req_i  (disp_req_i),
    .scan_addr_o (fb_re_addr_o),
    .pix_valid_o (pix_valid_o)
  );

  // Gated so the display sees 0 rather than stale RAM output when idle.
  assign pix_data_o = pix_valid_o ? fb_rd_data_i : '0;

  // Writers are locked out for the whole clear, including its DONE cycle.
  assign a_ready_o = a_valid_i & (st_q == CLR_IDLE);
  assign b_ready_o = b_valid_i & ~a_valid_i & (st_q == CLR_IDLE);

  always_comb begin
    st_d       = st_q;
    clr_cnt_d  = clr_cnt_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    case (st_q)
      CLR_IDLE: begin
        if (clr_start_i) begin
          st_d      = CLR_CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLR_CLEAR: begin
        clr_busy_o = 1'b1;
        if (clr_cnt_q == ADDR_W'(NPIX - 1)) st_d = CLR_DONE;
        else                                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
      CLR_DONE: begin
        clr_done_o = 1'b1;
        st_d       = CLR_IDLE;
      end
      default: st_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    wx     = a_ready_o ? a_x_i    : b_x_i;
    wy     = a_ready_o ? a_y_i    : b_y_i;
    wdat   = a_ready_o ? a_data_i : b_data_i;
    we_d   = 1'b0;
    oob_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (st_q == CLR_CLEAR) begin
      we_d   = 1'b1;
      addr_d = clr_cnt_q;
      data_d = CLR_VAL;
    end else if (a_ready_o || b_ready_o) begin
      // Out-of-range requests are still acknowledged, just never written.
      if (int'(wx) >= H_RES || int'(wy) >= FB_V_RES) begin
        oob_d = 1'b1;
      end else begin
        we_d   = 1'b1;
        addr_d = xy2addr(wx, wy);
        data_d = wdat;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q      <= CLR_IDLE;
      clr_cnt_q <= '0;
      we_q      <= 1'b0;
      oob_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      st_q      <= st_d;
      clr_cnt_q <= clr_cnt_d;
      we_q      <= we_d;
      oob_q     <= oob_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign fb_we_o      = we_q;
  assign oob_err_o    = oob_q;
  assign fb_wr_addr_o = addr_q;
  assign fb_wr_data_o = data_q;
endmodule

// File: tb/tb_pru_fb_arbiter.sv
// Scoreboard bench for pru_fb_arbiter with a reduced frame height to keep clears short.
module tb_pru_fb_arbiter;
  import pru_fb_pkg::*;

  localparam int VR = 8;
  localparam int NP = H_RES * VR;

  logic clk = 1'b0;
  logic rst, sof, disp_req, a_valid, b_valid, clr_start;
  logic [9:0] a_x, b_x;
  logic [8:0] a_y, b_y;
  logic [DATA_W-1:0] a_data, b_data;
  logic pix_valid, a_ready, b_ready, clr_busy, clr_done, oob_err, fb_we;
  logic [DATA_W-1:0] pix_data, fb_wr_data, fb_rd_data;
  logic [ADDR_W-1:0] fb_wr_addr, fb_re_addr;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct { bit we; int addr; int data; bit oob; } wr_t;
  wr_t wq[$];
  int  pq[$];
  wr_t me;

  logic [DATA_W-1:0] mem     [0:NP-1];
  logic [DATA_W-1:0] ref_mem [0:NP-1];

  int m_scan, m_clr, m_cnt;
  bit pend_we;
  int pend_addr, pend_data;
  bit acc_a, acc_b;

  always #5 clk = ~clk;

  pru_fb_arbiter #(.FB_V_RES(VR)) dut (
    .clk_i(clk), .rst_i(rst), .sof_i(sof), .disp_req_i(disp_req),
    .pix_valid_o(pix_valid), .pix_data_o(pix_data),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_x_i(a_x), .a_y_i(a_y), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_x_i(b_x), .b_y_i(b_y), .b_data_i(b_data),
    .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done), .oob_err_o(oob_err),
    .fb_we_o(fb_we), .fb_wr_addr_o(fb_wr_addr), .fb_wr_data_o(fb_wr_data),
    .fb_re_addr_o(fb_re_addr), .fb_rd_data_i(fb_rd_data)
  );

  // Registered-read, read-first buffer.
  always @(posedge clk) begin
    fb_rd_data <= mem[fb_re_addr];
    if (fb_we) mem[fb_wr_addr] <= fb_wr_data;
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (pix_valid) begin
      if (pq.size() == 0) chk("pix_unexpected", int'(pix_valid), 0);
      else                chk("pix_data", int'(pix_data), pq.pop_front());
    end
    if (fb_we || oob_err) begin
      if (wq.size() == 0) chk("wr_unexpected", int'(fb_we | oob_err), 0);
      else begin
        me = wq.pop_front();
        chk("fb_we", int'(fb_we), int'(me.we));
        chk("oob_err", int'(oob_err), int'(me.oob));
        if (me.we) begin
          chk("fb_wr_addr", int'(fb_wr_addr), me.addr);
          chk("fb_wr_data", int'(fb_wr_data), me.data);
        end
      end
    end
  end

  task automatic idle_in();
    sof = 0; disp_req = 0; clr_start = 0;
    a_valid = 0; a_x = '0; a_y = '0; a_data = '0;
    b_valid = 0; b_x = '0; b_y = '0; b_data = '0;
  endtask

  task automatic issue(int x, int y, int d);
    wr_t e;
    if (x >= H_RES || y >= VR) e = '{0, 0, 0, 1};
    else begin
      e = '{1, y * H_RES + x, d, 0};
      pend_we = 1; pend_addr = e.addr; pend_data = d;
    end
    wq.push_back(e);
  endtask

  // One clock: inputs are already driven at the preceding negedge.
  task automatic tick();
    bit exp_ar, exp_br;
    #1;
    exp_ar = a_valid && (m_clr == 0);
    exp_br = b_valid && !a_valid && (m_clr == 0);
    chk("a_ready", int'(a_ready), int'(exp_ar));
    chk("b_ready", int'(b_ready), int'(exp_br));
    chk("fb_re_addr", int'(fb_re_addr), m_scan);
    chk("clr_busy", int'(clr_busy), int'(m_clr == 1));
    chk("clr_done", int'(clr_done), int'(m_clr == 2));
    acc_a = exp_ar; acc_b = exp_br;
    if (disp_req) pq.push_back(int'(ref_mem[m_scan]));
    if (pend_we) ref_mem[pend_addr] = pend_data[DATA_W-1:0];
    pend_we = 0;
    if (m_clr == 1) begin
      wq.push_back('{1, m_cnt, int'(CLR_VAL), 0});
      pend_we = 1; pend_addr = m_cnt; pend_data = int'(CLR_VAL);
    end else if (exp_ar) issue(int'(a_x), int'(a_y), int'(a_data));
    else if (exp_br)     issue(int'(b_x), int'(b_y), int'(b_data));
    if (sof)           m_scan = 0;
    else if (disp_req) m_scan = (m_scan + 1) % NP;
    case (m_clr)
      0: if (clr_start) begin m_clr = 1; m_cnt = 0; end
      1: if (m_cnt == NP - 1) m_clr = 2; else m_cnt++;
      default: m_clr = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero();
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_a_ready", int'(a_ready), 0);
    chk("rst_b_ready", int'(b_ready), 0);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_clr_done", int'(clr_done), 0);
    chk("rst_oob_err", int'(oob_err), 0);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_wr_addr", int'(fb_wr_addr), 0);
    chk("rst_fb_wr_data", int'(fb_wr_data), 0);
    chk("rst_fb_re_addr", int'(fb_re_addr), 0);
  endtask

  task automatic do_reset(int n);
    rst = 1; idle_in();
    if (pend_we) ref_mem[pend_addr] = pend_data[DATA_W-1:0];
    pend_we = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_zero();
    rst = 0;
    m_scan = 0; m_clr = 0; m_cnt = 0; acc_a = 0; acc_b = 0;
  endtask

  task automatic rand_writers();
    if (!a_valid || acc_a) begin
      a_valid = 1'($urandom_range(0, 1));
      a_x = 10'($urandom_range(0, 700)); a_y = 9'($urandom_range(0, VR + 2));
      a_data = 2'($urandom);
    end
    if (!b_valid || acc_b) begin
      b_valid = 1'($urandom_range(0, 1));
      b_x = 10'($urandom_range(0, 700)); b_y = 9'($urandom_range(0, VR + 2));
      b_data = 2'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NP; i++) begin
      mem[i] = 2'(i % 4);
      ref_mem[i] = 2'(i % 4);
    end
    pend_we = 0; acc_a = 0; acc_b = 0;
    idle_in();
    rst = 1;
    @(posedge clk);
    do_reset(3);
    mon_en = 1;

    // Raster read of a preloaded buffer.
    sof = 1; tick(); sof = 0;
    disp_req = 1; repeat (5) tick(); disp_req = 0;

    // A beats B, B wins next cycle.
    a_valid = 1; a_x = 10'd3; a_y = 9'd2; a_data = 2'd1;
    b_valid = 1; b_x = 10'd5; b_y = 9'd0; b_data = 2'd2;
    tick();
    a_valid = 0; tick();
    b_valid = 0; tick();

    // Out-of-range writes.
    a_valid = 1; a_x = 10'd640; a_y = 9'd0; tick();
    a_x = 10'd0; a_y = 9'(VR); tick();
    a_valid = 0; tick();

    // Full clear with A held throughout; A wins the start cycle.
    a_valid = 1; a_x = 10'd7; a_y = 9'd1; a_data = 2'd3; clr_start = 1;
    tick();
    while (m_clr != 0) begin
      clr_start = 1'($urandom_range(0, 1));
      tick();
    end
    clr_start = 0; tick();
    a_valid = 0; tick();

    // Reset mid-clear.
    clr_start = 1; tick(); clr_start = 0;
    while (!(m_clr == 1 && m_cnt == 1000)) tick();
    do_reset(1);
    a_valid = 1; a_x = 10'd1; a_y = 9'd0; a_data = 2'd2; tick();
    a_valid = 0; repeat (2) tick();

    // Held disp_req across the frame wrap, with background writes.
    disp_req = 1;
    for (int i = 0; i < NP + 4; i++) begin
      rand_writers();
      tick();
    end
    sof = 1; tick(); sof = 0; tick(); tick();
    disp_req = 0;

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      sof = ($urandom_range(0, 63) == 0);
      disp_req = 1'($urandom_range(0, 1));
      rand_writers();
      tick();
    end

    idle_in();
    repeat (3) tick();
    chk("pix_queue_drained", pq.size(), 0);
    chk("wr_queue_drained", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
